// File: rtl/usart_tx_if.sv
// Host-side bundle of the USART transmitter: byte write port, FIFO status and serial line.
// The master side is the host writing bytes; the slave side is the transmitter itself.
interface usart_tx_if;
  logic [7:0] data_in;
  logic       wr_en;
  logic       full;
  logic       empty;
  logic       busy;
  logic       overflow;
  logic       tx;

  modport master (
    output data_in, wr_en,
    input  full, empty, busy, overflow, tx
  );

  modport slave (
    input  data_in, wr_en,
    output full, empty, busy, overflow, tx
  );
endinterface

// File: rtl/usart_tx.sv
// UART transmitter: small byte FIFO feeding a start/8 data/parity/stop frame serialiser,
// paced by a programmable bit timer. Line idles high.
module usart_tx #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input logic        clock,
  input logic        reset,
  usart_tx_if.slave  bus
);

  localparam int unsigned TW = $clog2(CLKS_PER_BIT);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic          STOP_LAST  = 1'(STOP_BITS - 1);
  localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_e;

  // FIFO state
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          overflow_q, overflow_d;
  logic          push, pop;
  logic [7:0]    head;

  // Serialiser state
  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic          stop_idx_q, stop_idx_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          tick;

  assign head = mem_q[rd_ptr_q];
  assign tick = (timer_q == TIMER_LAST);

  // A write against a full FIFO is dropped even if a pop frees a slot on the same edge.
  always_comb begin
    push       = bus.wr_en && !full_q;
    wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d    = count_q;
    if (push && !pop) count_d = count_q + CW'(1);
    if (pop && !push) count_d = count_q - CW'(1);
    overflow_d = overflow_q || (bus.wr_en && full_q);
    full_d     = (count_d == COUNT_FULL);
    empty_d    = (count_d == '0);
  end

  // NOTE: FIFO storage has no reset; pointers and count define which entries are valid.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= bus.data_in;
  end

  // NOTE: every signal gets its default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d    = state_q;
    timer_d    = tick ? '0 : timer_q + TW'(1);
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    par_d      = par_q;
    stop_idx_d = stop_idx_q;
    pop        = 1'b0;

    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (!empty_q) begin
          pop     = 1'b1;
          shift_d = head;
          par_d   = (PARITY == 2) ? ~^head : ^head;
          state_d = START;
        end
      end
      START: begin
        if (tick) begin
          state_d   = DATA;
          bit_idx_d = 3'd0;
        end
      end
      DATA: begin
        if (tick) begin
          shift_d   = shift_q >> 1;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d    = (PARITY != 0) ? PAR : STOP;
            stop_idx_d = 1'b0;
          end
        end
      end
      PAR: begin
        if (tick) begin
          state_d    = STOP;
          stop_idx_d = 1'b0;
        end
      end
      STOP: begin
        if (tick) begin
          if (stop_idx_q == STOP_LAST) begin
            // Chain straight into the next start bit when more data is queued.
            if (!empty_q) begin
              pop     = 1'b1;
              shift_d = head;
              par_d   = (PARITY == 2) ? ~^head : ^head;
              state_d = START;
            end else begin
              state_d = IDLE;
            end
          end else begin
            stop_idx_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d == START && state_q != START) timer_d = '0;

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PAR:     tx_d = par_d;
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
  end

  // NOTE: registers update with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
      state_q    <= IDLE;
      timer_q    <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      stop_idx_q <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      timer_q    <= timer_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      stop_idx_q <= stop_idx_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.tx       = tx_q;
  assign bus.busy     = busy_q;
  assign bus.full     = full_q;
  assign bus.empty    = empty_q;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_usart_tx.sv
// Directed bench for usart_tx: five parameterisations share one clock/reset and a
// selector routes the write strobe to, and the status/line back from, the unit under test.
module tb_usart_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [7:0] data_in;
  int         sel;
  int         cpb;
  int         tests = 0;
  int         fails = 0;

  logic tx_m, busy_m, full_m, empty_m, ovf_m;

  logic       mon_en;
  logic [7:0] mon_b;
  logic [7:0] rx_q [$];

  always #5 clk = ~clk;

  usart_tx_if if_a ();
  usart_tx_if if_e ();
  usart_tx_if if_o ();
  usart_tx_if if_s ();
  usart_tx_if if_m ();

  assign if_a.data_in = data_in;
  assign if_e.data_in = data_in;
  assign if_o.data_in = data_in;
  assign if_s.data_in = data_in;
  assign if_m.data_in = data_in;
  assign if_a.wr_en = wr_en && (sel == 0);
  assign if_e.wr_en = wr_en && (sel == 1);
  assign if_o.wr_en = wr_en && (sel == 2);
  assign if_s.wr_en = wr_en && (sel == 3);
  assign if_m.wr_en = wr_en && (sel == 4);

  usart_tx #(.CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4))
    dut_a (.clock(clk), .reset(rst), .bus(if_a));
  usart_tx #(.CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4))
    dut_e (.clock(clk), .reset(rst), .bus(if_e));
  usart_tx #(.CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4))
    dut_o (.clock(clk), .reset(rst), .bus(if_o));
  usart_tx #(.CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4))
    dut_s (.clock(clk), .reset(rst), .bus(if_s));
  usart_tx #(.CLKS_PER_BIT(2), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4))
    dut_m (.clock(clk), .reset(rst), .bus(if_m));

  always_comb begin
    tx_m = if_a.tx; busy_m = if_a.busy; full_m = if_a.full;
    empty_m = if_a.empty; ovf_m = if_a.overflow;
    case (sel)
      1: begin tx_m = if_e.tx; busy_m = if_e.busy; full_m = if_e.full; empty_m = if_e.empty; ovf_m = if_e.overflow; end
      2: begin tx_m = if_o.tx; busy_m = if_o.busy; full_m = if_o.full; empty_m = if_o.empty; ovf_m = if_o.overflow; end
      3: begin tx_m = if_s.tx; busy_m = if_s.busy; full_m = if_s.full; empty_m = if_s.empty; ovf_m = if_s.overflow; end
      4: begin tx_m = if_m.tx; busy_m = if_m.busy; full_m = if_m.full; empty_m = if_m.empty; ovf_m = if_m.overflow; end
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called on a negedge; returns on the negedge after the accepting edge.
  task automatic write1(input logic [7:0] b);
    data_in = b;
    wr_en   = 1'b1;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  // Called on the negedge of the first start-bit cycle; checks every cycle of the frame.
  task automatic frame(input logic [7:0] d, input bit has_par, input logic pbit,
                       input int nstop, input string tag);
    logic [11:0] bits;
    int          n;
    logic        got;
    logic        busy_got;
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = d[i];
    n = 9;
    if (has_par) begin bits[n] = pbit; n++; end
    n += nstop;
    busy_got = 1'b1;
    for (int b = 0; b < n; b++) begin
      got = bits[b];
      for (int c = 0; c < cpb; c++) begin
        if (tx_m !== bits[b]) got = tx_m;
        if (busy_m !== 1'b1) busy_got = busy_m;
        @(negedge clk);
      end
      check($sformatf("%s_bit%0d", tag, b), 32'(got), 32'(bits[b]));
    end
    check($sformatf("%s_busy", tag), 32'(busy_got), 32'd1);
  endtask

  // Background line decoder used where frames overlap with ongoing writes.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && tx_m === 1'b0) begin
        repeat (cpb) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          mon_b[i] = tx_m;
          repeat (cpb) @(negedge clk);
        end
        rx_q.push_back(mon_b);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic line_ok;
    rst = 1'b1; wr_en = 1'b0; data_in = '0; sel = 0; cpb = 4; mon_en = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx_m), 32'd1);
    check("rst_busy", 32'(busy_m), 32'd0);
    check("rst_full", 32'(full_m), 32'd0);
    check("rst_empty", 32'(empty_m), 32'd1);
    check("rst_overflow", 32'(ovf_m), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 0x55, no parity, 1 stop: tx still high one edge after the write, low after the next.
    write1(8'h55);
    check("f55_lat_tx", 32'(tx_m), 32'd1);
    check("f55_lat_busy", 32'(busy_m), 32'd0);
    check("f55_empty_after_write", 32'(empty_m), 32'd0);
    @(negedge clk);
    frame(8'h55, 1'b0, 1'b0, 1, "f55");
    check("f55_busy_end", 32'(busy_m), 32'd0);
    check("f55_tx_end", 32'(tx_m), 32'd1);
    check("f55_empty_end", 32'(empty_m), 32'd1);

    // Even parity of 0x07 is 1, odd parity is 0.
    sel = 1;
    write1(8'h07);
    @(negedge clk);
    frame(8'h07, 1'b1, 1'b1, 1, "fev");
    check("fev_busy_end", 32'(busy_m), 32'd0);
    sel = 2;
    write1(8'h07);
    @(negedge clk);
    frame(8'h07, 1'b1, 1'b0, 1, "fod");
    check("fod_busy_end", 32'(busy_m), 32'd0);

    // Two stop bits, back-to-back bytes with no idle cycle between frames.
    sel = 3;
    data_in = 8'hA3; wr_en = 1'b1;
    @(negedge clk);
    data_in = 8'h3C;
    @(negedge clk);
    wr_en = 1'b0;
    frame(8'hA3, 1'b0, 1'b0, 2, "fa3");
    frame(8'h3C, 1'b0, 1'b0, 2, "f3c");
    check("s2_busy_end", 32'(busy_m), 32'd0);
    check("s2_tx_end", 32'(tx_m), 32'd1);

    // Minimum bit period of two clocks.
    sel = 4; cpb = 2;
    data_in = 8'hFF; wr_en = 1'b1;
    @(negedge clk);
    data_in = 8'h00;
    @(negedge clk);
    wr_en = 1'b0;
    frame(8'hFF, 1'b0, 1'b0, 1, "fff");
    frame(8'h00, 1'b0, 1'b0, 1, "f00");
    check("m_busy_end", 32'(busy_m), 32'd0);
    cpb = 4;

    // Seven writes on consecutive cycles into a depth-4 FIFO: the last two are dropped.
    sel = 0;
    rx_q.delete();
    mon_en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (i == 5) check("ovf_after_five", 32'(ovf_m), 32'd0);
      data_in = 8'h10 + 8'(i);
      wr_en   = 1'b1;
      @(negedge clk);
    end
    wr_en = 1'b0;
    check("ovf_full", 32'(full_m), 32'd1);
    check("ovf_flag", 32'(ovf_m), 32'd1);
    repeat (400) @(negedge clk);
    mon_en = 1'b0;
    check("ovf_frame_count", 32'(rx_q.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < rx_q.size()) check($sformatf("ovf_byte%0d", i), 32'(rx_q[i]), 32'(8'h10 + 8'(i)));
    end
    check("ovf_sticky", 32'(ovf_m), 32'd1);
    check("ovf_empty_end", 32'(empty_m), 32'd1);

    // Reset mid data bit 3 of 0x81 with two more bytes still queued.
    data_in = 8'h81; wr_en = 1'b1;
    @(negedge clk);
    data_in = 8'h82;
    @(negedge clk);
    data_in = 8'h83;
    @(negedge clk);
    wr_en = 1'b0;
    repeat (17) @(negedge clk);
    check("mid_tx_bit3", 32'(tx_m), 32'd0);
    check("mid_empty_before", 32'(empty_m), 32'd0);
    rst = 1'b1;
    #1;
    check("mid_rst_tx", 32'(tx_m), 32'd1);
    check("mid_rst_empty", 32'(empty_m), 32'd1);
    check("mid_rst_busy", 32'(busy_m), 32'd0);
    check("mid_rst_overflow", 32'(ovf_m), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    line_ok = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (tx_m !== 1'b1 || busy_m !== 1'b0) line_ok = 1'b0;
    end
    check("mid_line_quiet", 32'(line_ok), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
